pid_delay_tap: RTL and testbench
================================

PID_DELAY_TAP -- requirements
Module: pid_delay_tap

Interface
REQ-001 Parameter WIDTH, default 16, sample width in bits.
REQ-002 Parameter DEPTH_LOG2, default 5, log2 of circular buffer depth; DEPTH = 2**DEPTH_LOG2.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 ce  input  1  sample enable; high = accept i and advance the line this cycle.
REQ-006 clr  input  1  synchronous clear; priority over ce.
REQ-007 i  input  WIDTH  input sample.
REQ-008 delay  input  DEPTH_LOG2  requested tap delay D in accepted samples, range 0..DEPTH-1; sampled only when ce=1.
REQ-009 o  output  WIDTH  registered delayed sample.
REQ-010 o_valid  output  1  high when o holds a sample delayed by exactly the latched D.
REQ-011 rearm  output  1  one-clk pulse when a change in delay is latched.

Function
REQ-012 Storage: DEPTH x WIDTH circular buffer; write pointer wp of DEPTH_LOG2 bits, wrapping DEPTH-1 -> 0.
REQ-013 Accepted sample: a cycle with ce=1 and clr=0 writes i to buf[wp], then increments wp.
REQ-014 Output: at the edge accepting sample x[n], o <= x[n-D]; D=0 bypasses the buffer, o <= i.
REQ-015 Read address for D>0 = (wp - D) mod DEPTH, evaluated before the write; the write and read of the same edge never alias because D<DEPTH.
REQ-016 Latency: o and o_valid change only on accepted-sample edges (or clr/reset); one clk register stage after acceptance, none between.
REQ-017 ce=0: buffer, wp, o, o_valid, the FSM and the fill count all hold.
REQ-018 FSM states: IDLE (no sample since arm), FILL (0 < fill_cnt <= D), RUN (o_valid=1).
REQ-019 fill_cnt counts accepted samples since the last arm, including the current one, and saturates at DEPTH.
REQ-020 IDLE -> FILL on an accepted sample when D>0.
REQ-021 IDLE -> RUN directly on an accepted sample when D=0.
REQ-022 FILL -> RUN at the accepting edge where fill_cnt reaches D+1.
REQ-023 o_valid is 1 in RUN and 0 otherwise; in IDLE and FILL, o still updates per REQ-014 but is don't-care to consumers.
REQ-024 Delay change: on an accepted sample with delay != latched D, latch the new D, pulse rearm, and set fill_cnt=1.
REQ-025 After a delay change, the state is RUN if the new D=0, else FILL; o_valid drops that same edge.
REQ-026 After a delay change, o <= x[n-newD] per REQ-014; buffer contents and wp are retained.
REQ-027 clr=1 (any ce): wp=0, fill_cnt=0, o=0, o_valid=0, rearm=0, state IDLE; the latched D is loaded from delay.
REQ-028 Buffer contents are not cleared by clr and need not be; o_valid gating covers stale data.
REQ-029 Simultaneous clr and ce: clr wins and the sample is discarded.
REQ-030 Arithmetic is unsigned modulo DEPTH on pointers; no sign handling on data, which passes bit-exact.

Reset
REQ-031 resetn low asynchronously forces o=0, o_valid=0, rearm=0, wp=0, fill_cnt=0, latched D=0, state IDLE.
REQ-032 Release of resetn is synchronised internally (two-flop) before the first accepted sample.
REQ-033 Buffer RAM has no reset.

Verification
REQ-034 WIDTH=16, DEPTH_LOG2=5, D=3, ce=1 every cycle, i=1,2,3,...; o_valid rises at the 4th accepted sample with o=1, and thereafter o=i-3 every cycle.
REQ-035 D=3, ce toggling 1,0,1,0; o advances only on ce=1 cycles, o_valid timing counts only accepted samples, and o equals the sample 3 accepts earlier.
REQ-036 D=31 with 40 samples, covering wp wrap; the 32nd accept gives o=1 with o_valid=1, and the 40th gives o=9.
REQ-037 Running at D=3, change delay to 5 on sample 20; that edge pulses rearm, o_valid=0 and o=15; o_valid returns at the 5th following accept, sample 25, with o=20.
REQ-038 clr asserted with ce=1 mid-RUN; o=0 and o_valid=0 next edge, and the sample is dropped; D=0 then the next accept gives o=i with o_valid=1.
REQ-039 resetn pulled low asynchronously mid-FILL; outputs go to 0 without a clock edge; after release, a fresh fill is required before o_valid=1.

Source files
------------

// File: rtl/pid_delay_tap.sv
// Circular-buffer delay tap: o is the input delayed by a programmable number of
// accepted samples, with a fill tracker that flags when the output is trustworthy.
`timescale 1ns/1ps
module pid_delay_tap #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ce,
    input  logic                  clr,
    input  logic [WIDTH-1:0]      i,
    input  logic [DEPTH_LOG2-1:0] delay,
    output logic [WIDTH-1:0]      o,
    output logic                  o_valid,
    output logic                  rearm
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [1:0]            rst_sync;
    logic                  ready;
    logic                  acc;
    logic                  changed;
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] d_lat;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [DEPTH_LOG2:0]   fill_cnt;
    logic [DEPTH_LOG2:0]   fill_nxt;
    logic [DEPTH_LOG2:0]   d_plus1;
    logic [WIDTH-1:0]      tap_p0;
    state_t                state;
    state_t                state_nxt;
    logic [WIDTH-1:0]      o_p1;
    logic                  vld_p1;
    logic                  rearm_p1;

    function automatic logic [DEPTH_LOG2:0] sat_inc(input logic [DEPTH_LOG2:0] v);
        if (v >= CNT_MAX)
            return CNT_MAX;
        return v + CNT_ONE;
    endfunction

    // Release of resetn is re-timed so the first accept sees a clean edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign ready = rst_sync[1];

    // Stage p0: tap selection and next-state decision, read before this edge's write.
    always_comb begin
        acc      = ce & ~clr & ready;
        changed  = (delay != d_lat);
        rd_addr  = wp - delay;
        tap_p0   = (delay == '0) ? i : mem[rd_addr];
        fill_nxt = changed ? CNT_ONE : sat_inc(fill_cnt);
        d_plus1  = {1'b0, delay} + CNT_ONE;
        if (delay == '0)
            state_nxt = RUN;
        else if (!changed && state == RUN)
            state_nxt = RUN;
        else if (fill_nxt >= d_plus1)
            state_nxt = RUN;
        else
            state_nxt = FILL;
    end

    always_ff @(posedge clk) begin
        if (acc)
            mem[wp] <= i;
    end

    // Stage p1: registered output, valid flag and tracker state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp       <= '0;
            d_lat    <= '0;
            fill_cnt <= '0;
            state    <= IDLE;
            o_p1     <= '0;
            vld_p1   <= 1'b0;
            rearm_p1 <= 1'b0;
        end else begin
            rearm_p1 <= 1'b0;
            if (clr) begin
                wp       <= '0;
                d_lat    <= delay;
                fill_cnt <= '0;
                state    <= IDLE;
                o_p1     <= '0;
                vld_p1   <= 1'b0;
            end else if (acc) begin
                wp       <= wp + PTR_ONE;
                d_lat    <= delay;
                fill_cnt <= fill_nxt;
                state    <= state_nxt;
                o_p1     <= tap_p0;
                vld_p1   <= (state_nxt == RUN);
                rearm_p1 <= changed;
            end
        end
    end

    assign o       = o_p1;
    assign o_valid = vld_p1;
    assign rearm   = rearm_p1;
endmodule

// File: tb/tb_pid_delay_tap.sv
// Directed bench for pid_delay_tap: a history-queue model checked every cycle,
// plus literal expectations at the interesting accepts.
`timescale 1ns/1ps
module tb_pid_delay_tap;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        ce = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] i = '0;
    logic [4:0]  delay = '0;
    logic [15:0] o;
    logic        o_valid;
    logic        rearm;

    int n_tests = 0;
    int n_fail  = 0;

    pid_delay_tap #(.WIDTH(16), .DEPTH_LOG2(5)) dut (
        .clk(clk), .resetn(resetn), .ce(ce), .clr(clr), .i(i),
        .delay(delay), .o(o), .o_valid(o_valid), .rearm(rearm)
    );

    always #5 clk = ~clk;

    // Model: history of accepted samples since the last arm point.
    int        rel = 0;
    int        m_d = 0;
    int        m_cnt = 0;
    logic [15:0] m_o = '0;
    logic      m_ok = 1'b1;
    logic      m_v = 1'b0;
    logic      m_re = 1'b0;
    logic [15:0] xs[$];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rel = 0; m_d = 0; m_cnt = 0; m_o = '0; m_ok = 1'b1;
            m_v = 1'b0; m_re = 1'b0; xs.delete();
        end else begin
            m_re = 1'b0;
            if (clr) begin
                m_d = int'(delay); m_cnt = 0; m_o = '0; m_ok = 1'b1;
                m_v = 1'b0; xs.delete();
            end else if (ce && rel >= 2) begin
                if (int'(delay) != m_d) begin
                    m_re = 1'b1; m_cnt = 1; m_d = int'(delay);
                end else begin
                    m_cnt++;
                end
                xs.push_back(i);
                if (m_d == 0) begin
                    m_o = i; m_ok = 1'b1;
                end else if (xs.size() > m_d) begin
                    m_o = xs[xs.size() - 1 - m_d]; m_ok = 1'b1;
                end else begin
                    m_ok = 1'b0;
                end
                m_v = (m_cnt >= m_d + 1);
            end
            if (rel < 2) rel++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_o_valid", {31'b0, o_valid}, {31'b0, m_v});
        chk("model_rearm", {31'b0, rearm}, {31'b0, m_re});
        if (m_ok) chk("model_o", {16'b0, o}, {16'b0, m_o});
    end

    task automatic step(input logic c, input logic cl, input logic [15:0] x, input logic [4:0] d);
        ce = c; clr = cl; i = x; delay = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 resetn = 1'b0;
        #10;
        chk("reset_o", {16'b0, o}, 32'd0);
        chk("reset_valid", {31'b0, o_valid}, 32'd0);
        chk("reset_rearm", {31'b0, rearm}, 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        repeat (4) step(1'b0, 1'b0, 16'd0, 5'd0);

        // Steady D=3 ramp
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b0, 16'(k), 5'd3);
            if (k == 1) chk("ramp_rearm_first", {31'b0, rearm}, 32'd1);
            if (k == 3) chk("ramp_valid_k3", {31'b0, o_valid}, 32'd0);
            if (k == 4) begin
                chk("ramp_o_k4", {16'b0, o}, 32'd1);
                chk("ramp_valid_k4", {31'b0, o_valid}, 32'd1);
            end
            if (k == 10) chk("ramp_o_k10", {16'b0, o}, 32'd7);
        end

        // ce toggling
        step(1'b0, 1'b1, 16'd0, 5'd3);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 16'(100 + k), 5'd3);
            if (k == 1) chk("tog_rearm_after_clr", {31'b0, rearm}, 32'd0);
            if (k == 3) chk("tog_valid_k3", {31'b0, o_valid}, 32'd0);
            if (k == 4) begin
                chk("tog_o_k4", {16'b0, o}, 32'd101);
                chk("tog_valid_k4", {31'b0, o_valid}, 32'd1);
            end
            if (k == 6) chk("tog_o_k6", {16'b0, o}, 32'd103);
            step(1'b0, 1'b0, 16'd999, 5'd3);
            if (k == 4) chk("tog_hold_o", {16'b0, o}, 32'd101);
        end

        // Maximum delay with pointer wrap
        step(1'b0, 1'b1, 16'd0, 5'd31);
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, 1'b0, 16'(k), 5'd31);
            if (k == 31) chk("wrap_valid_k31", {31'b0, o_valid}, 32'd0);
            if (k == 32) begin
                chk("wrap_o_k32", {16'b0, o}, 32'd1);
                chk("wrap_valid_k32", {31'b0, o_valid}, 32'd1);
            end
            if (k == 40) chk("wrap_o_k40", {16'b0, o}, 32'd9);
        end

        // Delay change 3 -> 5 at sample 20
        step(1'b0, 1'b1, 16'd0, 5'd3);
        for (int k = 1; k <= 30; k++) begin
            step(1'b1, 1'b0, 16'(k), (k >= 20) ? 5'd5 : 5'd3);
            if (k == 19) chk("chg_o_k19", {16'b0, o}, 32'd16);
            if (k == 20) begin
                chk("chg_rearm_k20", {31'b0, rearm}, 32'd1);
                chk("chg_valid_k20", {31'b0, o_valid}, 32'd0);
                chk("chg_o_k20", {16'b0, o}, 32'd15);
            end
            if (k == 21) chk("chg_rearm_k21", {31'b0, rearm}, 32'd0);
            if (k == 24) chk("chg_valid_k24", {31'b0, o_valid}, 32'd0);
            if (k == 25) begin
                chk("chg_o_k25", {16'b0, o}, 32'd20);
                chk("chg_valid_k25", {31'b0, o_valid}, 32'd1);
            end
            if (k == 30) chk("chg_o_k30", {16'b0, o}, 32'd25);
        end

        // clr with ce mid-RUN, then bypass
        step(1'b1, 1'b1, 16'd777, 5'd0);
        chk("clr_o", {16'b0, o}, 32'd0);
        chk("clr_valid", {31'b0, o_valid}, 32'd0);
        step(1'b1, 1'b0, 16'd55, 5'd0);
        chk("byp_o", {16'b0, o}, 32'd55);
        chk("byp_valid", {31'b0, o_valid}, 32'd1);
        chk("byp_rearm", {31'b0, rearm}, 32'd0);
        step(1'b1, 1'b0, 16'hFFFF, 5'd0);
        chk("byp_o_ones", {16'b0, o}, 32'h0000FFFF);
        step(1'b0, 1'b0, 16'd1234, 5'd0);
        chk("byp_hold", {16'b0, o}, 32'h0000FFFF);

        // Async reset mid-FILL
        step(1'b0, 1'b1, 16'd0, 5'd4);
        step(1'b1, 1'b0, 16'd1, 5'd4);
        step(1'b1, 1'b0, 16'd2, 5'd4);
        ce = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("areset_o", {16'b0, o}, 32'd0);
        chk("areset_valid", {31'b0, o_valid}, 32'd0);
        chk("areset_rearm", {31'b0, rearm}, 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        repeat (4) step(1'b0, 1'b0, 16'd0, 5'd4);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b0, 16'(k), 5'd4);
            if (k == 1) chk("refill_rearm", {31'b0, rearm}, 32'd1);
            if (k == 4) chk("refill_valid_k4", {31'b0, o_valid}, 32'd0);
            if (k == 5) begin
                chk("refill_valid_k5", {31'b0, o_valid}, 32'd1);
                chk("refill_o_k5", {16'b0, o}, 32'd1);
            end
        end
        step(1'b0, 1'b0, 16'd0, 5'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
